// File: rtl/var_bw_mul_pkg.sv
// Shared types and helpers for the variable bit-width pipelined multiplier.
// The signed-lane payload bit exists only when VAR_BW_MUL_SIGNED_EN is defined.
package var_bw_mul_pkg;

  localparam int unsigned MAX_LANES = 4;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Control that travels down the pipe alongside the data
  typedef struct packed {
    logic  err;
`ifdef VAR_BW_MUL_SIGNED_EN
    logic  sgn;
`endif
    mode_e mode;
  } meta_t;

  // Lane width for a given operand width and lane mode
  function automatic int unsigned lane_width(input int unsigned w, input mode_e mode);
    return (mode == MODE_HALF) ? (w / 2) : ((mode == MODE_QUARTER) ? (w / 4) : w);
  endfunction

endpackage

// File: rtl/var_bw_mul_pp_array.sv
// Quarter-by-quarter partial-product array and mode-dependent product assembly.
// Split into a front half (partial products + signed corrections) and a back
// half (summing) so the parent can place a register between them.
module var_bw_mul_pp_array
  import var_bw_mul_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]                                     a,
  input  logic [W-1:0]                                     b,
  input  logic                                             sgn,
  output logic [MAX_LANES*MAX_LANES-1:0][2*(W/4)-1:0]      pp_c,
  output logic [3*W-1:0]                                   corr_c,
  input  logic [MAX_LANES*MAX_LANES-1:0][2*(W/4)-1:0]      pp_in,
  input  logic [3*W-1:0]                                   corr_in,
  input  mode_e                                            mode,
  output logic [2*W-1:0]                                   p_c
);

  localparam int unsigned Q  = lane_width(W, MODE_QUARTER);
  localparam int unsigned HW = lane_width(W, MODE_HALF);
  localparam int unsigned PQ = 2 * Q;
  localparam int unsigned PW = 2 * W;

  logic [W-1:0]                cf, cf_in;
  logic [1:0][HW-1:0]          ch, ch_in;
  logic [MAX_LANES-1:0][Q-1:0] cq, cq_in;
  logic [PW-1:0]               full;
  logic [1:0][W-1:0]           half;
  logic [MAX_LANES-1:0][PQ-1:0] quar;

  // Unsigned quarter x quarter partial products
  always_comb begin
    pp_c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      for (int j = 0; j < MAX_LANES; j++) begin
        pp_c[i*MAX_LANES+j] = PQ'(a[i*Q +: Q]) * PQ'(b[j*Q +: Q]);
      end
    end
  end

  // Two's-complement corrections per lane: subtract (a<0 ? b : 0) + (b<0 ? a : 0) from the upper half
  always_comb begin
    cf = '0;
    ch = '0;
    cq = '0;
    if (sgn) begin
      cf = (a[W-1] ? b : '0) + (b[W-1] ? a : '0);
      for (int h = 0; h < 2; h++) begin
        ch[h] = (a[h*HW+HW-1] ? b[h*HW +: HW] : '0) + (b[h*HW+HW-1] ? a[h*HW +: HW] : '0);
      end
      for (int k = 0; k < MAX_LANES; k++) begin
        cq[k] = (a[k*Q+Q-1] ? b[k*Q +: Q] : '0) + (b[k*Q+Q-1] ? a[k*Q +: Q] : '0);
      end
    end
  end

  assign corr_c = {cq, ch, cf};
  assign {cq_in, ch_in, cf_in} = corr_in;

  // Sum the relevant partial products per lane, each lane truncated to its own width
  always_comb begin
    full = '0;
    half = '0;
    quar = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      for (int j = 0; j < MAX_LANES; j++) begin
        full = full + (PW'(pp_in[i*MAX_LANES+j]) << (Q * (i + j)));
      end
    end
    full = full - {cf_in, {W{1'b0}}};
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          half[h] = half[h] + (W'(pp_in[(2*h+i)*MAX_LANES + 2*h + j]) << (Q * (i + j)));
        end
      end
      half[h] = half[h] - {ch_in[h], {HW{1'b0}}};
    end
    for (int k = 0; k < MAX_LANES; k++) begin
      quar[k] = pp_in[k*(MAX_LANES+1)] - {cq_in[k], {Q{1'b0}}};
    end
    p_c = full;
    case (mode)
      MODE_HALF:    p_c = half;
      MODE_QUARTER: p_c = quar;
      default:      p_c = full;
    endcase
  end

endmodule

// File: rtl/var_bw_mul_pipe.sv
// Pipelined variable bit-width multiplier: 1xW, 2xW/2 or 4xW/4 lanes per
// transaction, valid/ready on both sides, all stages stall together.
// Optional signed lanes via VAR_BW_MUL_SIGNED_EN (adds in_sgn / out_sgn).
module var_bw_mul_pipe
  import var_bw_mul_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_mode,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
`ifdef VAR_BW_MUL_SIGNED_EN
  input  logic           in_sgn,
  output logic           out_sgn,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic [1:0]     out_mode,
  output logic           out_err
);

  localparam int unsigned PPW = MAX_LANES * MAX_LANES * 2 * (W / 4);
  localparam int unsigned CW  = 3 * W;
  localparam int unsigned P0  = (STAGES >= 2) ? 1 : 0;
  localparam int unsigned NPR = STAGES - P0;

  logic             adv;
  logic             sgn_c;
  meta_t            meta_in;
  logic [PPW-1:0]   pp_c;
  logic [PPW-1:0]   pp_s;
  logic [CW-1:0]    corr_c;
  logic [CW-1:0]    corr_s;
  mode_e            mode_s;
  logic [2*W-1:0]   prod_c;
  logic [STAGES-1:0] vld_q;
  meta_t            meta_q [STAGES];
  logic [2*W-1:0]   prod_q [NPR];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

`ifdef VAR_BW_MUL_SIGNED_EN
  assign sgn_c = in_sgn;
`else
  assign sgn_c = 1'b0;
`endif

  // Reserved mode runs as a full-width multiply and is flagged
  always_comb begin
    meta_in      = '0;
    meta_in.err  = (in_mode == 2'(MODE_RSVD));
    meta_in.mode = meta_in.err ? MODE_FULL : mode_e'(in_mode);
`ifdef VAR_BW_MUL_SIGNED_EN
    meta_in.sgn  = in_sgn;
`endif
  end

  var_bw_mul_pp_array #(.W(W)) u_pp (
    .a       (in_a),
    .b       (in_b),
    .sgn     (sgn_c),
    .pp_c    (pp_c),
    .corr_c  (corr_c),
    .pp_in   (pp_s),
    .corr_in (corr_s),
    .mode    (mode_s),
    .p_c     (prod_c)
  );

  if (P0 == 1) begin : g_pp_reg
    logic [PPW-1:0] pp_q;
    logic [CW-1:0]  corr_q;

    // Stage 1 holds partial products; summing happens in stage 2
    always_ff @(posedge clk) begin
      if (rst) begin
        pp_q   <= '0;
        corr_q <= '0;
      end else if (adv) begin
        pp_q   <= pp_c;
        corr_q <= corr_c;
      end
    end

    assign pp_s   = pp_q;
    assign corr_s = corr_q;
    assign mode_s = meta_q[0].mode;
  end else begin : g_pp_comb
    assign pp_s   = pp_c;
    assign corr_s = corr_c;
    assign mode_s = meta_in.mode;
  end

  // Valid, control and product shift registers; everything holds when adv=0
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) meta_q[s] <= '0;
      for (int k = 0; k < NPR; k++) prod_q[k] <= '0;
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      meta_q[0] <= meta_in;
      prod_q[0] <= prod_c;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        meta_q[s] <= meta_q[s-1];
      end
      for (int k = 1; k < NPR; k++) prod_q[k] <= prod_q[k-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_p     = prod_q[NPR-1];
  assign out_mode  = meta_q[STAGES-1].mode;
  assign out_err   = meta_q[STAGES-1].err;
`ifdef VAR_BW_MUL_SIGNED_EN
  assign out_sgn   = meta_q[STAGES-1].sgn;
`endif

endmodule

// File: tb/tb_var_bw_mul_pipe.sv
// Directed self-checking bench for var_bw_mul_pipe (W=16, STAGES=2).
module tb_var_bw_mul_pipe;

  localparam int unsigned W      = 16;
  localparam int unsigned STAGES = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic [1:0]     out_mode;
  logic           out_err;
`ifdef VAR_BW_MUL_SIGNED_EN
  logic           in_sgn;
  logic           out_sgn;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  var_bw_mul_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef VAR_BW_MUL_SIGNED_EN
    .in_sgn    (in_sgn),
    .out_sgn   (out_sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_mode  (out_mode),
    .out_err   (out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef VAR_BW_MUL_SIGNED_EN
    in_sgn = 1'b0;
`endif
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_p !== 32'h0) begin bad++; $display("FAIL reset_p got=%h exp=00000000", out_p); end
    total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", out_mode); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_full();
    in_mode = 2'd0; in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_a = 16'h1357; in_b = 16'h2468;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_early got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    total++; if (out_p !== 32'hFFFE0001) begin bad++; $display("FAIL full_p got=%h exp=fffe0001", out_p); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", out_err); end
    total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL full_mode got=%0d exp=0", out_mode); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_modes();
    logic [1:0]     m [2];
    logic [W-1:0]   a [2];
    logic [W-1:0]   b [2];
    logic [2*W-1:0] e [2];
    m[0] = 2'd1; a[0] = 16'hFF02; b[0] = 16'hFF03; e[0] = 32'hFE010006;
    m[1] = 2'd2; a[1] = 16'hF321; b[1] = 16'hF123; e[1] = 32'hE1030403;
    for (int i = 0; i < 2; i++) begin
      in_mode = m[i]; in_a = a[i]; in_b = b[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL modes_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_p !== e[i]) begin bad++; $display("FAIL modes_p[%0d] got=%h exp=%h", i, out_p, e[i]); end
      total++; if (out_mode !== m[i]) begin bad++; $display("FAIL modes_mode[%0d] got=%0d exp=%0d", i, out_mode, m[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]     m [4];
    logic [W-1:0]   a [4];
    logic [W-1:0]   b [4];
    logic [2*W-1:0] e [4];
    logic [1:0]     em [4];
    logic           ee [4];
    m[0] = 2'd0; a[0] = 16'h1234; b[0] = 16'h0010; e[0] = 32'h00012340; em[0] = 2'd0; ee[0] = 1'b0;
    m[1] = 2'd1; a[1] = 16'h0A0B; b[1] = 16'h0C0D; e[1] = 32'h0078008F; em[1] = 2'd1; ee[1] = 1'b0;
    m[2] = 2'd2; a[2] = 16'h1234; b[2] = 16'h5678; e[2] = 32'h050C1520; em[2] = 2'd2; ee[2] = 1'b0;
    m[3] = 2'd3; a[3] = 16'h0003; b[3] = 16'h0005; e[3] = 32'h0000000F; em[3] = 2'd0; ee[3] = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_mode = m[c]; in_a = a[c]; in_b = b[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 4) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", c-1, out_valid); end
        total++; if (out_p !== e[c-1]) begin bad++; $display("FAIL b2b_p[%0d] got=%h exp=%h", c-1, out_p, e[c-1]); end
        total++; if (out_mode !== em[c-1]) begin bad++; $display("FAIL b2b_mode[%0d] got=%0d exp=%0d", c-1, out_mode, em[c-1]); end
        total++; if (out_err !== ee[c-1]) begin bad++; $display("FAIL b2b_err[%0d] got=%b exp=%b", c-1, out_err, ee[c-1]); end
      end
      if (c == 5) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]     m [4];
    logic [W-1:0]   a [4];
    logic [W-1:0]   b [4];
    logic [2*W-1:0] e [4];
    int issued;
    int got;
    m[0] = 2'd0; a[0] = 16'h0101; b[0] = 16'h0101; e[0] = 32'h00010201;
    m[1] = 2'd1; a[1] = 16'h0203; b[1] = 16'h0405; e[1] = 32'h0008000F;
    m[2] = 2'd2; a[2] = 16'h1111; b[2] = 16'h2222; e[2] = 32'h02020202;
    m[3] = 2'd0; a[3] = 16'h8000; b[3] = 16'h0002; e[3] = 32'h00010000;
    issued = 0;
    got    = 0;
    for (int c = 0; c < 40; c++) begin
      if (got == 4) break;
      out_ready = (c >= 6);
      in_valid  = (issued < 4);
      if (issued < 4) begin
        in_mode = m[issued]; in_a = a[issued]; in_b = b[issued];
      end
      #1;
      if (out_valid && !out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
        total++; if (out_p !== e[0]) begin bad++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, out_p, e[0]); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (got >= 4) begin
          bad++; $display("FAIL bp_extra got=%h exp=none", out_p);
        end else if (out_p !== e[got]) begin
          bad++; $display("FAIL bp_drain[%0d] got=%h exp=%h", got, out_p, e[got]);
        end
        got++;
      end
      if (in_valid && in_ready) issued++;
      step();
    end
    total++; if (got != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_mode = 2'd0; in_a = 16'h0007; in_b = 16'h0009; in_valid = 1'b1;
    step();
    in_mode = 2'd1; in_a = 16'h0102; in_b = 16'h0304;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    total++; if (out_p !== 32'h0) begin bad++; $display("FAIL rstmid_p got=%h exp=00000000", out_p); end
    for (int i = 0; i < STAGES; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale[%0d] got=%b exp=0", i, out_valid); end
    end
    in_mode = 2'd1; in_a = 16'h0A0B; in_b = 16'h0C0D; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_recover_v got=%b exp=1", out_valid); end
    total++; if (out_p !== 32'h0078008F) begin bad++; $display("FAIL rstmid_recover_p got=%h exp=0078008f", out_p); end
    step();
  endtask

`ifdef VAR_BW_MUL_SIGNED_EN
  task automatic test_signed();
    out_ready = 1'b1;
    in_mode = 2'd1; in_a = 16'hFF02; in_b = 16'h0203; in_sgn = 1'b1; in_valid = 1'b1;
    step();
    in_sgn = 1'b0;
    step();
    in_valid = 1'b0;
    total++; if (out_p !== 32'hFFFE0006) begin bad++; $display("FAIL sgn_p got=%h exp=fffe0006", out_p); end
    total++; if (out_sgn !== 1'b1) begin bad++; $display("FAIL sgn_flag got=%b exp=1", out_sgn); end
    step();
    total++; if (out_p !== 32'h01FE0006) begin bad++; $display("FAIL uns_p got=%h exp=01fe0006", out_p); end
    total++; if (out_sgn !== 1'b0) begin bad++; $display("FAIL uns_flag got=%b exp=0", out_sgn); end
    in_mode = 2'd0; in_a = 16'hFFFF; in_b = 16'h0003; in_sgn = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_sgn = 1'b0;
    step();
    total++; if (out_p !== 32'hFFFFFFFD) begin bad++; $display("FAIL sgn_full got=%h exp=fffffffd", out_p); end
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef VAR_BW_MUL_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
